// File: rtl/mem_access_unit_if.sv
// Bundle between EX, the MEM stage, the data-memory port and writeback.
// The unit itself attaches through the slave modport.
interface mem_access_unit_if #(
    parameter int XLEN      = 64,
    parameter int REGADDR_W = 5
);
    logic                 valid_i;
    logic                 ready_o;
    logic                 mem_read_i;
    logic                 mem_write_i;
    logic [2:0]           funct3_i;
    logic [XLEN-1:0]      alu_result_i;
    logic [XLEN-1:0]      store_data_i;
    logic [REGADDR_W-1:0] rd_i;
    logic                 dmem_req_o;
    logic                 dmem_we_o;
    logic [XLEN-1:0]      dmem_addr_o;
    logic [7:0]           dmem_be_o;
    logic [XLEN-1:0]      dmem_wdata_o;
    logic                 dmem_gnt_i;
    logic                 dmem_rvalid_i;
    logic [XLEN-1:0]      dmem_rdata_i;
    logic                 wb_valid_o;
    logic                 wb_we_o;
    logic [REGADDR_W-1:0] wb_rd_o;
    logic [XLEN-1:0]      wb_data_o;
    logic                 err_o;

    modport slave (
        input  valid_i, mem_read_i, mem_write_i, funct3_i, alu_result_i,
               store_data_i, rd_i, dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i,
        output ready_o, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o,
               dmem_wdata_o, wb_valid_o, wb_we_o, wb_rd_o, wb_data_o, err_o
    );

    modport master (
        output valid_i, mem_read_i, mem_write_i, funct3_i, alu_result_i,
               store_data_i, rd_i, dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i,
        input  ready_o, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o,
               dmem_wdata_o, wb_valid_o, wb_we_o, wb_rd_o, wb_data_o, err_o
    );
endinterface

// File: rtl/mem_access_unit.sv
// RV64I MEM stage: aligned loads/stores over a req/gnt/rvalid port, with
// sign/zero-extended writeback and ALU passthrough for non-memory ops.
module mem_access_unit #(
    parameter int XLEN      = 64,
    parameter int REGADDR_W = 5
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    mem_access_unit_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    state_e               state_r, state_s;

    logic                 is_load_r;
    logic [2:0]           funct3_r;
    logic [2:0]           offset_r;
    logic [REGADDR_W-1:0] rd_r;

    logic                 ready_r,      ready_s;
    logic                 dmem_req_r,   dmem_req_s;
    logic                 dmem_we_r,    dmem_we_s;
    logic [XLEN-1:0]      dmem_addr_r,  dmem_addr_s;
    logic [7:0]           dmem_be_r,    dmem_be_s;
    logic [XLEN-1:0]      dmem_wdata_r, dmem_wdata_s;
    logic                 wb_valid_r,   wb_valid_s;
    logic                 wb_we_r,      wb_we_s;
    logic [REGADDR_W-1:0] wb_rd_r,      wb_rd_s;
    logic [XLEN-1:0]      wb_data_r,    wb_data_s;
    logic                 err_r,        err_s;

    logic                 accept_s;
    logic                 mem_op_s;
    logic                 illegal_s;
    logic                 misaligned_s;
    logic [2:0]           in_offset_s;

    function automatic logic [7:0] byte_enables(input logic [1:0] size, input logic [2:0] off);
        logic [7:0] mask;
        case (size)
            2'b00:   mask = 8'h01;
            2'b01:   mask = 8'h03;
            2'b10:   mask = 8'h0F;
            default: mask = 8'hFF;
        endcase
        return mask << off;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
        logic mis;
        case (size)
            2'b00:   mis = 1'b0;
            2'b01:   mis = off[0];
            2'b10:   mis = (off[1:0] != 2'b00);
            default: mis = (off != 3'b000);
        endcase
        return mis;
    endfunction

    // Lane-select the read data, then truncate and sign/zero-extend by funct3.
    function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] rdata,
                                                    input logic [2:0]      f3,
                                                    input logic [2:0]      off);
        logic [XLEN-1:0] sh;
        logic            sx;
        logic [XLEN-1:0] res;
        sh = rdata >> {off, 3'b000};
        sx = ~f3[2];
        case (f3[1:0])
            2'b00:   res = {{(XLEN-8){sx & sh[7]}},   sh[7:0]};
            2'b01:   res = {{(XLEN-16){sx & sh[15]}}, sh[15:0]};
            2'b10:   res = {{(XLEN-32){sx & sh[31]}}, sh[31:0]};
            default: res = sh;
        endcase
        return res;
    endfunction

    // Decode of the operation presented by EX, used only on the accept edge.
    always_comb begin
        accept_s     = ready_r & bus.valid_i;
        mem_op_s     = bus.mem_read_i | bus.mem_write_i;
        in_offset_s  = bus.alu_result_i[2:0];
        misaligned_s = is_misaligned(bus.funct3_i[1:0], in_offset_s);
        if (bus.mem_read_i) begin
            illegal_s = (bus.funct3_i == 3'b111);
        end else begin
            illegal_s = bus.funct3_i[2];
        end
    end

    // Next-state and next-output decode; outputs are registered from these.
    always_comb begin
        state_s      = state_r;
        dmem_req_s   = dmem_req_r;
        dmem_we_s    = dmem_we_r;
        dmem_addr_s  = dmem_addr_r;
        dmem_be_s    = dmem_be_r;
        dmem_wdata_s = dmem_wdata_r;
        wb_valid_s   = 1'b0;
        wb_we_s      = 1'b0;
        wb_rd_s      = {REGADDR_W{1'b0}};
        wb_data_s    = {XLEN{1'b0}};
        err_s        = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (accept_s && !mem_op_s) begin
                    state_s    = ST_RESP;
                    wb_valid_s = 1'b1;
                    wb_we_s    = 1'b1;
                    wb_rd_s    = bus.rd_i;
                    wb_data_s  = bus.alu_result_i;
                end else if (accept_s && (illegal_s || misaligned_s)) begin
                    state_s    = ST_RESP;
                    wb_valid_s = 1'b1;
                    wb_rd_s    = bus.rd_i;
                    err_s      = 1'b1;
                end else if (accept_s) begin
                    // A read+write op is treated as a load, so only a pure write stores.
                    state_s      = ST_REQ;
                    dmem_req_s   = 1'b1;
                    dmem_we_s    = ~bus.mem_read_i;
                    dmem_addr_s  = {bus.alu_result_i[XLEN-1:3], 3'b000};
                    dmem_be_s    = byte_enables(bus.funct3_i[1:0], in_offset_s);
                    dmem_wdata_s = bus.store_data_i << {in_offset_s, 3'b000};
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (bus.dmem_gnt_i) begin
                    dmem_req_s   = 1'b0;
                    dmem_we_s    = 1'b0;
                    dmem_addr_s  = {XLEN{1'b0}};
                    dmem_be_s    = 8'h00;
                    dmem_wdata_s = {XLEN{1'b0}};
                    if (is_load_r) begin
                        state_s = ST_WAIT;
                    end else begin
                        state_s    = ST_RESP;
                        wb_valid_s = 1'b1;
                        wb_rd_s    = rd_r;
                    end
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (bus.dmem_rvalid_i) begin
                    state_s    = ST_RESP;
                    wb_valid_s = 1'b1;
                    wb_we_s    = 1'b1;
                    wb_rd_s    = rd_r;
                    wb_data_s  = load_extend(bus.dmem_rdata_i, funct3_r, offset_r);
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        ready_s = (state_s == ST_IDLE);
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operation context captured on accept for the grant and response phases.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            is_load_r <= 1'b0;
            funct3_r  <= 3'b000;
            offset_r  <= 3'b000;
            rd_r      <= {REGADDR_W{1'b0}};
        end else if (accept_s) begin
            is_load_r <= bus.mem_read_i;
            funct3_r  <= bus.funct3_i;
            offset_r  <= in_offset_s;
            rd_r      <= bus.rd_i;
        end else begin
            is_load_r <= is_load_r;
            funct3_r  <= funct3_r;
            offset_r  <= offset_r;
            rd_r      <= rd_r;
        end
    end

    // Output registers; reset clears the memory request asynchronously.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ready_r      <= 1'b1;
            dmem_req_r   <= 1'b0;
            dmem_we_r    <= 1'b0;
            dmem_addr_r  <= {XLEN{1'b0}};
            dmem_be_r    <= 8'h00;
            dmem_wdata_r <= {XLEN{1'b0}};
            wb_valid_r   <= 1'b0;
            wb_we_r      <= 1'b0;
            wb_rd_r      <= {REGADDR_W{1'b0}};
            wb_data_r    <= {XLEN{1'b0}};
            err_r        <= 1'b0;
        end else begin
            ready_r      <= ready_s;
            dmem_req_r   <= dmem_req_s;
            dmem_we_r    <= dmem_we_s;
            dmem_addr_r  <= dmem_addr_s;
            dmem_be_r    <= dmem_be_s;
            dmem_wdata_r <= dmem_wdata_s;
            wb_valid_r   <= wb_valid_s;
            wb_we_r      <= wb_we_s;
            wb_rd_r      <= wb_rd_s;
            wb_data_r    <= wb_data_s;
            err_r        <= err_s;
        end
    end

    assign bus.ready_o      = ready_r;
    assign bus.dmem_req_o   = dmem_req_r;
    assign bus.dmem_we_o    = dmem_we_r;
    assign bus.dmem_addr_o  = dmem_addr_r;
    assign bus.dmem_be_o    = dmem_be_r;
    assign bus.dmem_wdata_o = dmem_wdata_r;
    assign bus.wb_valid_o   = wb_valid_r;
    assign bus.wb_we_o      = wb_we_r;
    assign bus.wb_rd_o      = wb_rd_r;
    assign bus.wb_data_o    = wb_data_r;
    assign bus.err_o        = err_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, errors, passthrough,
// grant stalls and asynchronous reset mid-transaction.
module tb_mem_access_unit;

    localparam logic [63:0] RDATA = 64'hF0E1D2C3B4A59687;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    mem_access_unit_if #(.XLEN(64), .REGADDR_W(5)) bus ();

    mem_access_unit #(.XLEN(64), .REGADDR_W(5)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one op to the unit; returns 1 time unit after the accept edge.
    task automatic issue(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                         input logic [63:0] addr, input logic [63:0] sdata, input logic [4:0] rd);
        @(negedge clk);
        bus.valid_i      = 1'b1;
        bus.mem_read_i   = rd_en;
        bus.mem_write_i  = wr_en;
        bus.funct3_i     = f3;
        bus.alu_result_i = addr;
        bus.store_data_i = sdata;
        bus.rd_i         = rd;
        tick();
        bus.valid_i      = 1'b0;
        bus.mem_read_i   = 1'b0;
        bus.mem_write_i  = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [2:0] f3, input logic [63:0] addr,
                           input int stall, input logic [63:0] exp_addr, input logic [7:0] exp_be,
                           input logic [63:0] exp_data);
        issue(1'b1, 1'b0, f3, addr, 64'h0, 5'd9);
        for (int i = 0; i <= stall; i++) begin
            check_eq({tag, " req"},  {63'd0, bus.dmem_req_o}, 64'd1);
            check_eq({tag, " addr"}, bus.dmem_addr_o, exp_addr);
            if (i < stall) tick();
        end
        check_eq({tag, " be"}, {56'd0, bus.dmem_be_o}, {56'd0, exp_be});
        check_eq({tag, " we"}, {63'd0, bus.dmem_we_o}, 64'd0);
        bus.dmem_gnt_i = 1'b1;
        tick();
        bus.dmem_gnt_i   = 1'b0;
        check_eq({tag, " req after gnt"}, {63'd0, bus.dmem_req_o}, 64'd0);
        bus.dmem_rvalid_i = 1'b1;
        bus.dmem_rdata_i  = RDATA;
        tick();
        bus.dmem_rvalid_i = 1'b0;
        check_eq({tag, " wb_valid"}, {63'd0, bus.wb_valid_o}, 64'd1);
        check_eq({tag, " wb_we"},    {63'd0, bus.wb_we_o},    64'd1);
        check_eq({tag, " wb_rd"},    {59'd0, bus.wb_rd_o},    64'd9);
        check_eq({tag, " err"},      {63'd0, bus.err_o},      64'd0);
        check_eq({tag, " wb_data"},  bus.wb_data_o, exp_data);
        tick();
        check_eq({tag, " wb_valid low"}, {63'd0, bus.wb_valid_o}, 64'd0);
        check_eq({tag, " ready again"},  {63'd0, bus.ready_o},    64'd1);
    endtask

    // Ops that complete one cycle after accept without touching memory.
    task automatic do_single(input string tag, input logic rd_en, input logic wr_en,
                             input logic [2:0] f3, input logic [63:0] addr, input logic [4:0] rd,
                             input logic exp_we, input logic exp_err, input logic [63:0] exp_data);
        issue(rd_en, wr_en, f3, addr, 64'hDEAD, rd);
        check_eq({tag, " no req"},   {63'd0, bus.dmem_req_o}, 64'd0);
        check_eq({tag, " wb_valid"}, {63'd0, bus.wb_valid_o}, 64'd1);
        check_eq({tag, " wb_we"},    {63'd0, bus.wb_we_o},    {63'd0, exp_we});
        check_eq({tag, " err"},      {63'd0, bus.err_o},      {63'd0, exp_err});
        check_eq({tag, " wb_rd"},    {59'd0, bus.wb_rd_o},    {59'd0, rd});
        check_eq({tag, " wb_data"},  bus.wb_data_o, exp_data);
        tick();
        check_eq({tag, " wb_valid low"}, {63'd0, bus.wb_valid_o}, 64'd0);
        check_eq({tag, " err low"},      {63'd0, bus.err_o},      64'd0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n             = 1'b0;
        bus.valid_i       = 1'b0;
        bus.mem_read_i    = 1'b0;
        bus.mem_write_i   = 1'b0;
        bus.funct3_i      = 3'b000;
        bus.alu_result_i  = 64'h0;
        bus.store_data_i  = 64'h0;
        bus.rd_i          = 5'd0;
        bus.dmem_gnt_i    = 1'b0;
        bus.dmem_rvalid_i = 1'b0;
        bus.dmem_rdata_i  = 64'h0;
        #12;
        check_eq("reset ready",    {63'd0, bus.ready_o},    64'd1);
        check_eq("reset req",      {63'd0, bus.dmem_req_o}, 64'd0);
        check_eq("reset wb_valid", {63'd0, bus.wb_valid_o}, 64'd0);
        check_eq("reset wb_data",  bus.wb_data_o, 64'd0);
        rst_n = 1'b1;
        tick();

        do_load("LB",  3'b000, 64'h1003, 0, 64'h1000, 8'h08, 64'hFFFFFFFFFFFFFFB4);
        do_load("LBU", 3'b100, 64'h1003, 0, 64'h1000, 8'h08, 64'h00000000000000B4);
        do_load("LH",  3'b001, 64'h1006, 0, 64'h1000, 8'hC0, 64'hFFFFFFFFFFFFF0E1);
        do_load("LHU", 3'b101, 64'h1006, 0, 64'h1000, 8'hC0, 64'h000000000000F0E1);
        do_load("LW",  3'b010, 64'h1004, 0, 64'h1000, 8'hF0, 64'hFFFFFFFFF0E1D2C3);
        do_load("LWU", 3'b110, 64'h1004, 0, 64'h1000, 8'hF0, 64'h00000000F0E1D2C3);
        do_load("LD",  3'b011, 64'h1000, 0, 64'h1000, 8'hFF, RDATA);
        do_load("LD stall", 3'b011, 64'h1000, 5, 64'h1000, 8'hFF, RDATA);

        // SH @0x2006: upper halfword lanes.
        issue(1'b0, 1'b1, 3'b001, 64'h2006, 64'h1234, 5'd3);
        check_eq("SH req",   {63'd0, bus.dmem_req_o}, 64'd1);
        check_eq("SH we",    {63'd0, bus.dmem_we_o},  64'd1);
        check_eq("SH addr",  bus.dmem_addr_o, 64'h2000);
        check_eq("SH be",    {56'd0, bus.dmem_be_o}, 64'hC0);
        check_eq("SH wdata", bus.dmem_wdata_o, 64'h1234000000000000);
        bus.dmem_gnt_i = 1'b1;
        tick();
        bus.dmem_gnt_i = 1'b0;
        check_eq("SH wb_valid", {63'd0, bus.wb_valid_o}, 64'd1);
        check_eq("SH wb_we",    {63'd0, bus.wb_we_o},    64'd0);
        check_eq("SH err",      {63'd0, bus.err_o},      64'd0);
        tick();
        check_eq("SH wb_valid low", {63'd0, bus.wb_valid_o}, 64'd0);

        do_single("LW misaligned", 1'b1, 1'b0, 3'b010, 64'h1002, 5'd4, 1'b0, 1'b1, 64'd0);
        do_single("ST f3=100",     1'b0, 1'b1, 3'b100, 64'h2000, 5'd5, 1'b0, 1'b1, 64'd0);
        do_single("LD f3=111",     1'b1, 1'b0, 3'b111, 64'h2000, 5'd6, 1'b0, 1'b1, 64'd0);
        do_single("passthru",      1'b0, 1'b0, 3'b000, 64'h3C,   5'd7, 1'b1, 1'b0, 64'h3C);

        // Async reset while the request is outstanding.
        issue(1'b1, 1'b0, 3'b011, 64'h1000, 64'h0, 5'd2);
        check_eq("rstREQ req before", {63'd0, bus.dmem_req_o}, 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("rstREQ req",   {63'd0, bus.dmem_req_o}, 64'd0);
        check_eq("rstREQ ready", {63'd0, bus.ready_o},    64'd1);
        #1 rst_n = 1'b1;
        tick();

        // Async reset in WAIT; the late rvalid must be ignored.
        issue(1'b1, 1'b0, 3'b011, 64'h1000, 64'h0, 5'd2);
        bus.dmem_gnt_i = 1'b1;
        tick();
        bus.dmem_gnt_i = 1'b0;
        check_eq("rstWAIT ready before", {63'd0, bus.ready_o}, 64'd0);
        #1 rst_n = 1'b0;
        #1;
        check_eq("rstWAIT req",      {63'd0, bus.dmem_req_o}, 64'd0);
        check_eq("rstWAIT ready",    {63'd0, bus.ready_o},    64'd1);
        check_eq("rstWAIT wb_valid", {63'd0, bus.wb_valid_o}, 64'd0);
        #1 rst_n = 1'b1;
        tick();
        bus.dmem_rvalid_i = 1'b1;
        bus.dmem_rdata_i  = RDATA;
        tick();
        bus.dmem_rvalid_i = 1'b0;
        check_eq("late rvalid wb_valid", {63'd0, bus.wb_valid_o}, 64'd0);
        tick();
        check_eq("late rvalid wb_valid2", {63'd0, bus.wb_valid_o}, 64'd0);
        check_eq("late rvalid ready",     {63'd0, bus.ready_o},    64'd1);

        do_single("passthru after rst", 1'b0, 1'b0, 3'b000, 64'h55AA, 5'd31, 1'b1, 1'b0, 64'h55AA);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM stage of the RV64I core, directly downstream of the ALU.
- Takes the ALU result (effective address or arithmetic result), the store operand and control from EX.
- Performs aligned byte/half/word/doubleword loads and stores over a req/gnt/rvalid data-memory port, then presents sign- or zero-extended writeback data.
- Non-memory ops pass the ALU result through to writeback.

Parameters:
- XLEN, 64, datapath and address width. Only 64 is supported.
- REGADDR_W, 5, destination register index width.

Ports:
- clk_i  in  1  core clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- valid_i  in  1  EX presents an operation
- ready_o  out  1  unit can accept; high only in IDLE
- mem_read_i  in  1  load
- mem_write_i  in  1  store
- funct3_i  in  3  RV64I size/sign field
- alu_result_i  in  64  ALU result_o (address, or passthrough data)
- store_data_i  in  64  rs2 value
- rd_i  in  5  destination register
- dmem_req_o  out  1  memory request
- dmem_we_o  out  1  1 = write
- dmem_addr_o  out  64  doubleword-aligned address (alu_result & ~7)
- dmem_be_o  out  8  byte enables
- dmem_wdata_o  out  64  lane-aligned store data
- dmem_gnt_i  in  1  request accepted
- dmem_rvalid_i  in  1  read data valid
- dmem_rdata_i  in  64  read data
- wb_valid_o  out  1  one-cycle completion pulse
- wb_we_o  out  1  register write enable
- wb_rd_o  out  5  destination register
- wb_data_o  out  64  writeback value
- err_o  out  1  misaligned or illegal funct3; valid only with wb_valid_o

Behaviour:
- Reset (async, active-low): state forced to IDLE immediately. All outputs 0 except ready_o = 1. An in-flight transaction is abandoned, and dmem_req_o drops asynchronously.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: when valid_i && ready_o, latch all inputs.
  - Neither read nor write → RESP with wb_data = alu_result, wb_we = 1.
  - Both read and write set → treated as a load.
  - Error → RESP with err = 1, wb_we = 0, wb_data = 0, and no memory request.
  - Otherwise → REQ.
- Size is funct3[1:0]: 00 = B, 01 = H, 10 = W, 11 = D.
- Misaligned when the address low bits are nonzero for the size: H needs addr[0] = 0, W needs addr[1:0] = 0, D needs addr[2:0] = 0.
- Illegal funct3:
  - Loads: 111.
  - Stores: funct3[2] = 1.
- REQ: drive dmem_req_o = 1, dmem_we_o, dmem_addr_o, dmem_be_o and dmem_wdata_o. These must be held stable until dmem_gnt_i.
  - Byte enables are the size mask (0x01/0x03/0x0F/0xFF) shifted left by addr[2:0].
  - Store data is store_data_i shifted left by 8*addr[2:0].
  - On grant: store → RESP (wb_we = 0); load → WAIT.
  - No grant → remain in REQ indefinitely.
- WAIT: dmem_req_o = 0. dmem_rvalid_i is sampled only in this state.
  - On rvalid: extract rdata >> 8*addr[2:0] and truncate to size.
  - funct3[2] = 0 → sign-extend; funct3[2] = 1 → zero-extend.
  - Register the result → RESP.
- RESP: for exactly one cycle, wb_valid_o = 1 with wb_we_o, wb_rd_o, wb_data_o and err_o. Then → IDLE. The wb_* outputs return to 0 afterwards.
- Latency (accept edge = cycle 0):
  - Passthrough and error ops: wb_valid_o in cycle 1.
  - Load with grant in cycle 1 and rvalid in cycle 2: wb_valid_o in cycle 3.
  - ready_o is high again the cycle after RESP.
- Unexpected inputs: dmem_rvalid_i outside WAIT and dmem_gnt_i outside REQ are ignored. valid_i while not ready is ignored; EX must hold it.

Test Plan:
- rdata = 64'hF0E1D2C3B4A59687, LB @0x1003 → dmem_addr 0x1000, be 8'h08, wb_data 64'hFFFFFFFFFFFFFFB4. LBU at the same address → 64'h00000000000000B4.
- Same rdata, LW @0x1004 → 64'hFFFFFFFFF0E1D2C3. LWU → 64'h00000000F0E1D2C3. LD @0x1000 → the full rdata value.
- SH @0x2006 with store_data 0x1234 → dmem_addr 0x2000, be 8'hC0, wdata[63:48] = 16'h1234, we = 1. Completes with wb_valid = 1, wb_we = 0.
- LW @0x1002 → no dmem_req_o, err_o = 1, wb_we = 0 in cycle 1. Store with funct3 = 100 → err_o = 1.
- Passthrough (no read, no write) with alu_result 0x3C, rd = 7 → cycle 1: wb_valid = 1, wb_we = 1, wb_rd = 7, wb_data = 0x3C.
- LD with dmem_gnt_i held low 5 cycles → req/addr stable throughout, completes after grant and rvalid. rst_ni asserted in WAIT → dmem_req_o = 0, ready_o = 1, no wb_valid_o; a later rvalid is ignored.
